// File: rtl/mmio_bus_ctrl_pkg.sv
// mmio_bus_pkg: shared constants and types for the MMIO bus controller.
//   - Register offsets inside the 16-byte MMIO window
//   - STATUS / FAULT_STAT bit positions
//   - Drain FSM state and read-source select enums
package mmio_bus_pkg;

  // Register offsets relative to MMIO_BASE (word granular)
  localparam logic [3:0] TXDATA_OFS     = 4'h0;
  localparam logic [3:0] STATUS_OFS     = 4'h4;
  localparam logic [3:0] FAULT_ADDR_OFS = 4'h8;
  localparam logic [3:0] FAULT_STAT_OFS = 4'hC;

  localparam int unsigned MMIO_WINDOW_BYTES = 16;

  // STATUS register layout
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;
  localparam int STAT_COUNT_W   = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;

  // FAULT_STAT register layout
  localparam int FSTAT_VALID_BIT = 0;
  localparam int FSTAT_WRITE_BIT = 1;
  localparam int FSTAT_OVF_BIT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } drain_state_e;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_MMIO = 2'd1,
    SRC_ZERO = 2'd2
  } rd_src_e;

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// mmio_bus_ctrl_if: CPU data-port bundle between the CPU and mmio_bus_ctrl.
//   master (CPU)   : drives mem_read_cpu, mem_write_cpu, addr, data_from_cpu
//                    receives data_to_cpu, rd_valid, cpu_stall
//   slave (ctrl)   : mirror image of master
interface mmio_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mmio_bus_pkg::*;

  logic              mem_read_cpu;
  logic              mem_write_cpu;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_from_cpu;
  logic [DATA_W-1:0] data_to_cpu;
  logic              rd_valid;
  logic              cpu_stall;

  modport master (
    output mem_read_cpu, mem_write_cpu, addr, data_from_cpu,
    input  data_to_cpu, rd_valid, cpu_stall
  );

  modport slave (
    input  mem_read_cpu, mem_write_cpu, addr, data_from_cpu,
    output data_to_cpu, rd_valid, cpu_stall
  );

endinterface

// File: rtl/mmio_bus_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i        : write push_data_i (ignored when full)
//   pop_i         : drop head entry (ignored when empty)
//   head_o        : current head entry (valid when !empty_o)
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import mmio_bus_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Small register array: head is read asynchronously so the drain FSM
  // can present it in the same cycle it pops.
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: CPU data-port decoder for RAM, an MMIO register window and
// a UART transmit path with an auto-draining TX FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : CPU request/response (loads return after 1 cycle)
//   ram_*           : synchronous RAM port, data_from_ram one cycle after ram_read
//   uart_*          : UART transmitter strobe/data/busy
//   bus_fault       : fault record valid level
// Registers at MMIO_BASE: +0 TXDATA, +4 STATUS, +8 FAULT_ADDR, +C FAULT_STAT.
// Build option: define MMIO_FAULT_EN to implement unmapped-access capture
// (FAULT_ADDR/FAULT_STAT/bus_fault); without it those read 0 and bus_fault=0.
module mmio_bus_ctrl
  import mmio_bus_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RAM_BASE = 32'h0000_0000,
  parameter int              RAM_BYTES  = 16384,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 32'h0000_4000,
  parameter int              FIFO_DEPTH = 8,
  parameter int              UART_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmio_bus_ctrl_if.slave    bus,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_to_ram,
  input  logic [DATA_W-1:0] data_from_ram,
  output logic              uart_write,
  output logic [UART_W-1:0] uart_data,
  input  logic              uart_busy,
  output logic              bus_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0] ram_ofs, mmio_ofs;
  logic [3:0]        reg_ofs;
  logic              ram_hit, mmio_hit, txdata_hit;
  logic              rd_req, wr_req;

  // Offsets are computed by wrapping subtraction, so an address below a base
  // becomes huge and fails the single upper-bound compare.
  assign ram_ofs    = bus.addr - RAM_BASE;
  assign mmio_ofs   = bus.addr - MMIO_BASE;
  assign ram_hit    = (ram_ofs < ADDR_W'(RAM_BYTES));
  assign mmio_hit   = (mmio_ofs < ADDR_W'(MMIO_WINDOW_BYTES));
  assign reg_ofs    = {mmio_ofs[3:2], 2'b00};
  assign txdata_hit = mmio_hit && (reg_ofs == TXDATA_OFS);

  // A simultaneous read and write is treated as a write only.
  assign wr_req = bus.mem_write_cpu;
  assign rd_req = bus.mem_read_cpu && !bus.mem_write_cpu;

  assign ram_read    = rd_req && ram_hit;
  assign ram_write   = wr_req && ram_hit;
  assign ram_addr    = ram_ofs;
  assign data_to_ram = bus.data_from_cpu;

  // ---------------------------------------------------------------- TX FIFO
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  // Stall is based on the registered full flag, so a pop in the same cycle
  // frees the slot for the next cycle rather than this one.
  assign bus.cpu_stall = wr_req && txdata_hit && fifo_full;
  assign fifo_push     = wr_req && txdata_hit && !fifo_full;

  sync_fifo #(
    .WIDTH (UART_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (bus.data_from_cpu[UART_W-1:0]),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // ---------------------------------------------------------------- drain FSM
  drain_state_e state_q, state_d;

  always_comb begin
    state_d    = state_q;
    uart_write = 1'b0;
    uart_data  = '0;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !uart_busy) state_d = SEND;
      end
      SEND: begin
        uart_write = 1'b1;
        uart_data  = fifo_head;
        fifo_pop   = 1'b1;
        state_d    = HOLD;
      end
      // Give the UART one cycle to raise busy before re-checking it.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------- fault record
  logic [DATA_W-1:0] fault_addr_word, fault_stat_word;

`ifdef MMIO_FAULT_EN
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic              fault_valid_q, fault_valid_d;
  logic              fault_write_q, fault_write_d;
  logic              fault_ovf_q, fault_ovf_d;
  logic              fault_ev, fault_clr;

  assign fault_ev  = (bus.mem_read_cpu || bus.mem_write_cpu) && !ram_hit && !mmio_hit;
  assign fault_clr = wr_req && mmio_hit && (reg_ofs == FAULT_STAT_OFS);

  always_comb begin
    fault_addr_d  = fault_addr_q;
    fault_valid_d = fault_valid_q;
    fault_write_d = fault_write_q;
    fault_ovf_d   = fault_ovf_q;
    if (fault_ev) begin
      // A clear in the same cycle makes the new fault a fresh first record.
      if (fault_valid_q && !fault_clr) begin
        fault_ovf_d = 1'b1;
      end else begin
        fault_addr_d  = bus.addr;
        fault_write_d = wr_req;
        fault_valid_d = 1'b1;
        fault_ovf_d   = 1'b0;
      end
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
      fault_write_d = 1'b0;
      fault_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_addr_q  <= '0;
      fault_valid_q <= 1'b0;
      fault_write_q <= 1'b0;
      fault_ovf_q   <= 1'b0;
    end else begin
      fault_addr_q  <= fault_addr_d;
      fault_valid_q <= fault_valid_d;
      fault_write_q <= fault_write_d;
      fault_ovf_q   <= fault_ovf_d;
    end
  end

  always_comb begin
    fault_stat_word                  = '0;
    fault_stat_word[FSTAT_VALID_BIT] = fault_valid_q;
    fault_stat_word[FSTAT_WRITE_BIT] = fault_write_q;
    fault_stat_word[FSTAT_OVF_BIT]   = fault_ovf_q;
  end

  assign fault_addr_word = DATA_W'(fault_addr_q);
  assign bus_fault       = fault_valid_q;
`else
  assign fault_addr_word = '0;
  assign fault_stat_word = '0;
  assign bus_fault       = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  logic [DATA_W-1:0] status_word, mmio_rdata;

  always_comb begin
    status_word                                = '0;
    status_word[STAT_FULL_BIT]                 = fifo_full;
    status_word[STAT_EMPTY_BIT]                = fifo_empty;
    status_word[STAT_BUSY_BIT]                 = uart_busy;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = STAT_COUNT_W'(fifo_count);
  end

  always_comb begin
    case (reg_ofs)
      STATUS_OFS:     mmio_rdata = status_word;
      FAULT_ADDR_OFS: mmio_rdata = fault_addr_word;
      FAULT_STAT_OFS: mmio_rdata = fault_stat_word;
      default:        mmio_rdata = '0;
    endcase
  end

  // MMIO data is captured in the request cycle; RAM data arrives from the
  // RAM itself one cycle later, so only the source choice is registered.
  logic              rd_valid_q, rd_valid_d;
  rd_src_e           rd_src_q, rd_src_d;
  logic [DATA_W-1:0] mmio_rdata_q, mmio_rdata_d;
  logic [DATA_W-1:0] data_to_cpu_mux;

  always_comb begin
    rd_valid_d   = rd_req;
    mmio_rdata_d = mmio_rdata;
    if (ram_hit)       rd_src_d = SRC_RAM;
    else if (mmio_hit) rd_src_d = SRC_MMIO;
    else               rd_src_d = SRC_ZERO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q   <= 1'b0;
      rd_src_q     <= SRC_ZERO;
      mmio_rdata_q <= '0;
    end else begin
      rd_valid_q   <= rd_valid_d;
      rd_src_q     <= rd_src_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  always_comb begin
    data_to_cpu_mux = '0;
    if (rd_valid_q) begin
      case (rd_src_q)
        SRC_RAM:  data_to_cpu_mux = data_from_ram;
        SRC_MMIO: data_to_cpu_mux = mmio_rdata_q;
        default:  data_to_cpu_mux = '0;
      endcase
    end
  end

  assign bus.data_to_cpu = data_to_cpu_mux;
  assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
module tb_mmio_bus_ctrl;

  localparam int          DEPTH     = 8;
  localparam int          RAM_BYTES = 16384;
  localparam logic [31:0] MMIO_BASE = 32'h0000_4000;
`ifdef MMIO_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_read, ram_write, uart_write, uart_busy, bus_fault;
  logic [31:0] ram_addr, data_to_ram, data_from_ram;
  logic [7:0]  uart_data;

  mmio_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mmio_bus_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_addr      (ram_addr),
    .data_to_ram   (data_to_ram),
    .data_from_ram (data_from_ram),
    .uart_write    (uart_write),
    .uart_data     (uart_data),
    .uart_busy     (uart_busy),
    .bus_fault     (bus_fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the bus should look like, in terms of the
  // documented rules (queue of pending characters, cycle of last transmit).
  logic [7:0]  q[$];
  int          cyc;
  int          last_send;
  bit          send_now;
  bit          pend_v, pend_ram;
  logic [31:0] pend_d;
  bit          f_v, f_w, f_o;
  logic [31:0] f_a;

  // Observations captured by the most recent step
  logic        obs_rd_valid, obs_uart_write, obs_stall, obs_ram_read, obs_ram_write, obs_bus_fault;
  logic [31:0] obs_data;
  logic [7:0]  obs_uart_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < RAM_BYTES;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= MMIO_BASE) && (a < MMIO_BASE + 16);
  endfunction

  function automatic logic [31:0] mmio_value(input logic [31:0] a, input bit busy);
    int unsigned w, sz;
    w  = (a - MMIO_BASE) / 4;
    sz = q.size();
    case (w)
      1:       return (sz * 256) + (busy ? 4 : 0) + ((sz == 0) ? 2 : 0) + ((sz == DEPTH) ? 1 : 0);
      2:       return FAULT_EN ? f_a : 32'h0;
      3:       return FAULT_EN ? {29'h0, f_o, f_w, f_v} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    cyc       = 0;
    last_send = -100;
    send_now  = 1'b0;
    pend_v    = 1'b0;
    pend_ram  = 1'b0;
    pend_d    = 32'h0;
    f_v = 1'b0; f_w = 1'b0; f_o = 1'b0; f_a = 32'h0;
  endtask

  // One bus cycle: drive, compare everything against the model mid-cycle,
  // then advance the model across the clock edge.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input bit busy, input logic [31:0] rdat);
    bit tx, ramh, mmh, unm, clr, push_ok;
    int sz0;
    bus.mem_read_cpu  = rd;
    bus.mem_write_cpu = wr;
    bus.addr          = a;
    bus.data_from_cpu = wd;
    uart_busy         = busy;
    data_from_ram     = rdat;
    @(negedge clk);
    ramh = is_ram(a);
    mmh  = is_mmio(a);
    unm  = !ramh && !mmh;
    tx   = mmh && ((a - MMIO_BASE) / 4 == 0);
    clr  = wr && mmh && ((a - MMIO_BASE) / 4 == 3);
    sz0  = q.size();
    obs_rd_valid   = bus.rd_valid;
    obs_data       = bus.data_to_cpu;
    obs_stall      = bus.cpu_stall;
    obs_uart_write = uart_write;
    obs_uart_data  = uart_data;
    obs_ram_read   = ram_read;
    obs_ram_write  = ram_write;
    obs_bus_fault  = bus_fault;
    chk("rd_valid", {31'h0, bus.rd_valid}, {31'h0, pend_v});
    if (pend_v) chk("data_to_cpu", bus.data_to_cpu, pend_ram ? rdat : pend_d);
    chk("cpu_stall", {31'h0, bus.cpu_stall}, {31'h0, wr && tx && (sz0 == DEPTH)});
    chk("uart_write", {31'h0, uart_write}, {31'h0, send_now});
    if (send_now) chk("uart_data", {24'h0, uart_data}, {24'h0, q[0]});
    chk("ram_read", {31'h0, ram_read}, {31'h0, rd && !wr && ramh});
    chk("ram_write", {31'h0, ram_write}, {31'h0, wr && ramh});
    if (ramh && (rd || wr)) chk("ram_addr", ram_addr, a);
    chk("bus_fault", {31'h0, bus_fault}, {31'h0, FAULT_EN && f_v});
    @(posedge clk);
    // response for next cycle, sampled against the state at the start of this one
    pend_v   = rd && !wr;
    pend_ram = ramh;
    pend_d   = mmh ? mmio_value(a, busy) : 32'h0;
    // fault record
    if ((rd || wr) && unm) begin
      if (f_v && !clr) f_o = 1'b1;
      else begin f_a = a; f_w = wr; f_v = 1'b1; f_o = 1'b0; end
    end else if (clr) begin
      f_v = 1'b0; f_w = 1'b0; f_o = 1'b0;
    end
    // FIFO and transmit timing: a character goes out one cycle after the
    // drain logic sees data with the UART idle, no sooner than 3 cycles
    // after the previous character.
    push_ok = wr && tx && (sz0 < DEPTH);
    if (send_now) begin
      void'(q.pop_front());
      last_send = cyc;
      send_now  = 1'b0;
    end else begin
      send_now = (sz0 > 0) && !busy && (last_send <= cyc - 2);
    end
    if (push_ok) q.push_back(wd[7:0]);
    cyc++;
    #1;
  endtask

  task automatic idle(input bit busy);
    step(1'b0, 1'b0, 32'h0, 32'h0, busy, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_read_cpu = 1'b0; bus.mem_write_cpu = 1'b0;
    bus.addr = 32'h0; bus.data_from_cpu = 32'h0;
    uart_busy = 1'b0; data_from_ram = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    bit          e_ram_rd;
    bit          e_ram_wr;
    bit          e_valid;
    logic [31:0] e_data;
  } vec_t;

  vec_t        tbl[13];
  logic [7:0]  got[$];
  int          ok;
  int          nwr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // ---- reset state
    idle(1'b0);
    chk("rst_rd_valid", {31'h0, obs_rd_valid}, 32'h0);
    chk("rst_data", obs_data, 32'h0);
    chk("rst_uart_write", {31'h0, obs_uart_write}, 32'h0);
    chk("rst_uart_data", {24'h0, obs_uart_data}, 32'h0);
    chk("rst_bus_fault", {31'h0, obs_bus_fault}, 32'h0);

    // ---- decode / load-response table
    tbl[0]  = '{1, 0, 32'h0000_0100, 1, 0, 1, 32'hDEAD_BEEF};
    tbl[1]  = '{1, 0, 32'h0000_3FFC, 1, 0, 1, 32'hDEAD_BEEF};
    tbl[2]  = '{1, 0, 32'h0000_4004, 0, 0, 1, 32'h0000_0002};
    tbl[3]  = '{1, 0, 32'h0000_4000, 0, 0, 1, 32'h0000_0000};
    tbl[4]  = '{0, 1, 32'h0000_0200, 0, 1, 0, 32'h0};
    tbl[5]  = '{1, 1, 32'h0000_0300, 0, 1, 0, 32'h0};
    tbl[6]  = '{1, 0, 32'h0000_4010, 0, 0, 1, 32'h0};
    tbl[7]  = '{1, 0, 32'h0000_4008, 0, 0, 1, FAULT_EN ? 32'h0000_4010 : 32'h0};
    tbl[8]  = '{1, 0, 32'h0000_400C, 0, 0, 1, FAULT_EN ? 32'h1 : 32'h0};
    tbl[9]  = '{1, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'h0};
    tbl[10] = '{1, 0, 32'h0000_400C, 0, 0, 1, FAULT_EN ? 32'h5 : 32'h0};
    tbl[11] = '{0, 1, 32'h0000_400C, 0, 0, 0, 32'h0};
    tbl[12] = '{1, 0, 32'h0000_400C, 0, 0, 1, 32'h0};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].addr, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF);
      chk($sformatf("tbl%0d_ram_read", i), {31'h0, obs_ram_read}, {31'h0, tbl[i].e_ram_rd});
      chk($sformatf("tbl%0d_ram_write", i), {31'h0, obs_ram_write}, {31'h0, tbl[i].e_ram_wr});
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      chk($sformatf("tbl%0d_rd_valid", i), {31'h0, obs_rd_valid}, {31'h0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].e_data);
    end

    // ---- single character: strobe exactly 2 cycles after the push
    do_reset();
    step(1'b0, 1'b1, 32'h4000, 32'h41, 1'b0, 32'h0);
    idle(1'b0);
    chk("tx1_early", {31'h0, obs_uart_write}, 32'h0);
    idle(1'b0);
    chk("tx1_strobe", {31'h0, obs_uart_write}, 32'h1);
    chk("tx1_data", {24'h0, obs_uart_data}, 32'h41);
    idle(1'b0);
    step(1'b1, 1'b0, 32'h4004, 32'h0, 1'b0, 32'h0);
    idle(1'b0);
    chk("tx1_status", obs_data, 32'h0000_0002);

    // ---- fill the FIFO with the UART busy, stall the 9th store
    do_reset();
    got.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'h4000, 32'h41 + i, 1'b1, 32'h0);
      chk("fill_stall", {31'h0, obs_stall}, 32'h0);
    end
    step(1'b1, 1'b0, 32'h4004, 32'h0, 1'b1, 32'h0);
    idle(1'b1);
    chk("full_status", obs_data, 32'h0000_0805);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h4000, 32'h49, 1'b1, 32'h0);
      chk("full_stall", {31'h0, obs_stall}, 32'h1);
    end
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      step(1'b0, 1'b1, 32'h4000, 32'h49, 1'b0, 32'h0);
      if (obs_uart_write) got.push_back(obs_uart_data);
      if (!obs_stall) ok = 1;
    end
    chk("stall_release", ok, 1);
    for (int i = 0; i < 40; i++) begin
      idle(1'b0);
      if (obs_uart_write) got.push_back(obs_uart_data);
    end
    chk("tx9_count", got.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("tx9_char%0d", i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, 32'h41 + i);

    // ---- unmapped accesses and fault record
    do_reset();
    step(1'b0, 1'b1, 32'h8000, 32'h55, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h9000, 32'h0, 1'b0, 32'hCAFE_F00D);
    idle(1'b0);
    chk("unm_valid", {31'h0, obs_rd_valid}, 32'h1);
    chk("unm_data", obs_data, 32'h0);
    chk("fault_level", {31'h0, obs_bus_fault}, {31'h0, FAULT_EN});
    step(1'b1, 1'b0, 32'h4008, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h400C, 32'h0, 1'b0, 32'h0);
    chk("fault_addr", obs_data, FAULT_EN ? 32'h8000 : 32'h0);
    idle(1'b0);
    chk("fault_stat", obs_data, FAULT_EN ? 32'h7 : 32'h0);
    step(1'b0, 1'b1, 32'h400C, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h400C, 32'h0, 1'b0, 32'h0);
    chk("fault_cleared_level", {31'h0, obs_bus_fault}, 32'h0);
    idle(1'b0);
    chk("fault_cleared_stat", obs_data, 32'h0);

    // ---- reset with 3 characters queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h4000, 32'h30 + i, 1'b1, 32'h0);
    do_reset();
    step(1'b1, 1'b0, 32'h4004, 32'h0, 1'b0, 32'h0);
    idle(1'b0);
    chk("rst_fifo_status", obs_data, 32'h0000_0002);
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1'b0);
      if (obs_uart_write) nwr++;
    end
    chk("rst_no_tx", nwr, 0);

    // ---- randomized traffic against the model
    do_reset();
    begin
      bit          busy, rd, wr;
      logic [31:0] a;
      int          kind, op;
      busy = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) busy = !busy;
        kind = $urandom_range(0, 9);
        case (kind)
          0, 1, 2: a = $urandom_range(0, RAM_BYTES - 1);
          3, 4:    a = 32'h4000;
          5:       a = 32'h4004;
          6:       a = 32'h4008;
          7:       a = 32'h400C;
          8:       a = 32'h4010 + $urandom_range(0, 32'h7FFF_0000);
          default: a = 32'h4000 + $urandom_range(0, 15);
        endcase
        op = $urandom_range(0, 3);
        rd = (op == 1) || (op == 3);
        wr = (op == 2) || (op == 3);
        step(rd, wr, a, $urandom, busy, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
# mmio_bus_ctrl

Parametrised successor to the single-cycle CPU memory decoder. It sits between the CPU data port, the synchronous data RAM and the UART transmitter. It decodes RAM and MMIO regions and returns registered read data with a valid strobe. A TX FIFO drains automatically into the UART, so the CPU no longer polls busy per byte. It also captures accesses to unmapped addresses as bus faults.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RAM_BASE, 32'h0000_0000, RAM byte base
- RAM_BYTES, 16384, RAM size in bytes; power of 2, word aligned
- MMIO_BASE, 32'h0000_4000, base of the 16-byte register window
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, ≥2
- UART_W, 8, UART character width

Ports:
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- mem_read_cpu  in  1  CPU load request
- mem_write_cpu  in  1  CPU store request
- addr  in  ADDR_W  byte address
- data_from_cpu  in  DATA_W  store data
- data_to_cpu  out  DATA_W  load data; valid when rd_valid
- rd_valid  out  1  one-cycle pulse, load data valid
- cpu_stall  out  1  combinational; CPU must hold its request
- ram_read  out  1  RAM read enable
- ram_write  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM-relative byte address (addr − RAM_BASE)
- data_to_ram  out  DATA_W  equals data_from_cpu
- data_from_ram  in  DATA_W  RAM read data, one cycle after ram_read
- uart_write  out  1  one-cycle transmit strobe
- uart_data  out  UART_W  character to transmit
- uart_busy  in  1  UART transmitter busy
- bus_fault  out  1  level: fault record valid (MMIO_FAULT_EN only)

## Operation
- Decode:
  - RAM: RAM_BASE ≤ addr < RAM_BASE+RAM_BYTES.
  - MMIO: MMIO_BASE..+0xF.
  - Unmapped: anything else.
- Registers, offsets from MMIO_BASE:
  - +0x0 TXDATA. Write pushes data_from_cpu[UART_W-1:0]. Read returns 0.
  - +0x4 STATUS, read-only: bit0 fifo_full, bit1 fifo_empty, bit2 uart_busy, bits[15:8] fifo_count, rest 0.
  - +0x8 FAULT_ADDR, read-only.
  - +0xC FAULT_STAT: bit0 valid, bit1 was_write, bit2 overflow. Any write clears all three bits.
- Read and write asserted together: the write takes effect; no read response.
- Drain FSM:
  - IDLE: if !fifo_empty && !uart_busy, go to SEND.
  - SEND: uart_write=1, uart_data=head, pop, go to HOLD.
  - HOLD: one cycle for uart_busy to rise, then IDLE.
- Fault capture:
  - An unmapped access records addr and was_write, and sets valid.
  - An unmapped access while valid is already set leaves addr/was_write unchanged and sets overflow.
  - Unmapped reads still pulse rd_valid with data 0.
  - Unmapped writes are dropped.
- Arithmetic:
  - fifo_count is $clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.
  - FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - rd_valid=0, data_to_cpu=0, uart_write=0, uart_data=0.
  - FSM=IDLE, FIFO empty, fault record cleared, bus_fault=0.
  - ram_read, ram_write and cpu_stall follow their inputs combinationally.
- Load latency is 1 for every region:
  - Request in cycle N gives rd_valid and data_to_cpu in N+1.
  - A registered source select picks data_from_ram or the MMIO value sampled in N.
- RAM writes: ram_write is asserted combinationally in the request cycle.
- cpu_stall = mem_write_cpu && TXDATA hit && fifo_full.
  - While stalled, nothing is pushed.
  - The push completes in the first cycle the FIFO is not full.
  - A pop and a stalled push in the same cycle: the pop occurs; the push lands next cycle.
- Push into an empty FIFO with UART idle: uart_write pulses 2 cycles after the push cycle (the FIFO registers, then SEND).
- Character spacing: at least 3 cycles between uart_write pulses.
- FAULT_STAT clear and a new fault in the same cycle: the new fault wins, with valid=1 and overflow=0.
- rst mid-operation discards FIFO contents and aborts any pending response.

## Configuration
- MMIO_FAULT_EN defined:
  - The fault record, FAULT_ADDR and FAULT_STAT are implemented.
  - bus_fault mirrors FAULT_STAT.valid.
- MMIO_FAULT_EN undefined:
  - No fault logic; bus_fault is tied 0.
  - Offsets +0x8 and +0xC read 0, and writes to them are ignored.
  - Unmapped reads still return 0 with rd_valid.

## Structure
- Package mmio_bus_pkg:
  - register offset constants TXDATA_OFS, STATUS_OFS, FAULT_ADDR_OFS, FAULT_STAT_OFS
  - STATUS bit-index constants
  - drain FSM state enum {IDLE, SEND, HOLD}
  - read-source select enum {SRC_RAM, SRC_MMIO, SRC_ZERO}
- Sub-module sync_fifo, parametrised on width and depth, providing push, pop, full, empty and count.
- Decode, register file and drain FSM live in the top module.

## Test plan
- After reset, load STATUS → rd_valid next cycle, data 0x0000_0002 (empty, idle).
- Store 0x41 to 0x4000 with uart_busy=0 → uart_write pulse with uart_data=0x41 exactly 2 cycles later; STATUS returns to empty.
- Hold uart_busy=1 and store 9 characters with FIFO_DEPTH=8:
  - STATUS count reads 8 and full=1.
  - The 9th store stalls until uart_busy drops and the first pop occurs.
  - All 9 characters are transmitted in order.
- Load 0x0000_0100 from RAM with data_from_ram=0xDEADBEEF in the next cycle → data_to_cpu=0xDEADBEEF with rd_valid.
- Store to 0x8000, then load 0x9000 (MMIO_FAULT_EN):
  - bus_fault=1, FAULT_ADDR=0x8000, FAULT_STAT=0x7.
  - The load returns 0.
  - Writing 0x400C clears FAULT_STAT to 0 and bus_fault to 0.
- Assert rst while the FIFO holds 3 entries → FIFO empty next cycle and no further uart_write.
